// File: rtl/pool_arbiter_if.sv
// Bundle of request/release/drain inputs and grant/status outputs for pool_arbiter.
// master drives requests and releases; slave is the arbiter itself.
interface pool_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4,
  parameter int ID_WIDTH  = 2
);
  logic [NUM_REQ-1:0]   req;
  logic                 rel_valid;
  logic [ID_WIDTH-1:0]  rel_id;
  logic                 drain;
  logic [NUM_REQ-1:0]   grant;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 empty;
  logic                 drain_done;
  logic                 err_underflow;

  modport master (
    output req, rel_valid, rel_id, drain,
    input  grant, count, full, empty, drain_done, err_underflow
  );

  modport slave (
    input  req, rel_valid, rel_id, drain,
    output grant, count, full, empty, drain_done, err_underflow
  );
endinterface

// File: rtl/pool_arbiter.sv
// Round-robin arbiter handing out CAPACITY pooled slots to NUM_REQ requesters, with drain mode.
// Define POOL_ARB_OWNER_CHECK_EN to track per-requester holdings and reject releases by non-holders.
module pool_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CAPACITY  = 8,
  parameter int CNT_WIDTH = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic           clk,
  input  logic           rst,
  pool_arbiter_if.slave  bus
);
  localparam int                   PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0]          NR  = (PW+1)'(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CAP = CNT_WIDTH'(CAPACITY);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 err_q;
  logic                 eligible, found, g, rel_ok;
  logic [PW-1:0]        win;

  // Scan requesters starting at the pointer, wrapping past NUM_REQ-1 back to 0.
  always_comb begin : arbitrate
    logic [PW:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= NR) idx = idx - NR;
      if (!found && bus.req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign eligible = (state_q == ST_RUN) && !bus.drain && (count_q < CAP);
  assign g        = eligible && found;
  assign grant_d  = g ? (NUM_REQ'(1) << win) : '0;
  assign ptr_d    = !g ? ptr_q : ((win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1);

`ifdef POOL_ARB_OWNER_CHECK_EN
  logic [NUM_REQ-1:0] holds_any, rel_sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
    logic [CNT_WIDTH-1:0] hold_q;
    assign rel_sel[gi]   = (bus.rel_id == ID_WIDTH'(gi));
    assign holds_any[gi] = (hold_q != '0) || grant_d[gi];
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        hold_q <= '0;
      else if (grant_d[gi] && !(rel_ok && rel_sel[gi]))
        hold_q <= hold_q + 1'b1;
      else if (!grant_d[gi] && rel_ok && rel_sel[gi])
        hold_q <= hold_q - 1'b1;
    end
  end

  // Out-of-range ids match no rel_sel bit and are therefore rejected.
  assign rel_ok = bus.rel_valid && |(holds_any & rel_sel);
`else
  logic unused_rel_id;
  assign unused_rel_id = ^bus.rel_id;
  assign rel_ok        = bus.rel_valid && ((count_q != '0) || g);
`endif

  always_comb begin
    count_d = count_q;
    if (g && !rel_ok)
      count_d = count_q + 1'b1;
    else if (!g && rel_ok)
      count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (bus.drain) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.drain)          state_d = ST_RUN;
        else if (count_d == '0)  state_d = ST_DRAINED;
      end
      ST_DRAINED: if (!bus.drain) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      grant_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      count_q <= count_d;
      err_q   <= err_q | (bus.rel_valid & ~rel_ok);
    end
  end

  assign bus.grant         = grant_q;
  assign bus.count         = count_q;
  assign bus.full          = (count_q == CAP);
  assign bus.empty         = (count_q == '0);
  assign bus.drain_done    = (state_q == ST_DRAINED);
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_pool_arbiter.sv
// Self-checking bench for pool_arbiter: directed scenarios plus randomized traffic vs a queue-free slot model.
module tb_pool_arbiter;
  localparam int N   = 4;
  localparam int CAP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   fails = 0;

  pool_arbiter_if #(.NUM_REQ(N), .CNT_WIDTH(4), .ID_WIDTH(2)) bus ();

  pool_arbiter #(.NUM_REQ(N), .CAPACITY(CAP), .CNT_WIDTH(4), .ID_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: slot count, rotating priority start, mode (0 run, 1 draining, 2 drained).
  int         m_count, m_ptr, m_mode;
  bit         m_err;
  int         m_hold [N];
  logic [3:0] m_grant;

  task automatic model_reset();
    m_count = 0; m_ptr = 0; m_mode = 0; m_err = 0; m_grant = '0;
    for (int i = 0; i < N; i++) m_hold[i] = 0;
  endtask

  task automatic model_step();
    int win;
    bit gr, acc;
    win = -1; gr = 0; acc = 0;
    if (m_mode == 0 && !bus.drain && m_count < CAP)
      for (int k = 0; k < N; k++)
        if (win < 0 && bus.req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    m_grant = '0;
    if (win >= 0) begin
      m_grant[win] = 1'b1; gr = 1; m_ptr = (win + 1) % N;
    end
    if (bus.rel_valid) begin
`ifdef POOL_ARB_OWNER_CHECK_EN
      acc = (int'(bus.rel_id) < N) &&
            (m_hold[bus.rel_id] + ((gr && win == int'(bus.rel_id)) ? 1 : 0) > 0);
`else
      acc = (m_count + int'(gr)) > 0;
`endif
      if (!acc) m_err = 1;
    end
`ifdef POOL_ARB_OWNER_CHECK_EN
    if (gr) m_hold[win]++;
    if (acc) m_hold[bus.rel_id]--;
`endif
    m_count = m_count + int'(gr) - int'(acc);
    case (m_mode)
      0: if (bus.drain) m_mode = 1;
      1: if (!bus.drain) m_mode = 0; else if (m_count == 0) m_mode = 2;
      default: if (!bus.drain) m_mode = 0;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.rel_valid = 1'b0; bus.rel_id = '0; bus.drain = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    tests_run++;
    if ({bus.grant, bus.count, bus.full, bus.empty, bus.drain_done, bus.err_underflow} !== 12'b0000_0000_0100) begin
      fails++;
      $display("FAIL reset_state: got grant=%b count=%0d full=%b empty=%b dd=%b err=%b want 0,0,0,1,0,0",
               bus.grant, bus.count, bus.full, bus.empty, bus.drain_done, bus.err_underflow);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    logic [3:0] want;
    bus.req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      want = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
      tests_run++;
      if (bus.grant !== want || bus.count !== 4'((i < 8) ? i + 1 : 8)) begin
        fails++;
        $display("FAIL fill_step%0d: got grant=%b count=%0d want grant=%b count=%0d",
                 i, bus.grant, bus.count, want, (i < 8) ? i + 1 : 8);
      end
    end
    tests_run++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: got full=%b empty=%b want 1 0", bus.full, bus.empty);
    end
  endtask

  task automatic test_release_full();
    bus.req = 4'b0001; bus.rel_valid = 1'b1;
    tick();
    bus.rel_valid = 1'b0;
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.count !== 4'd7) begin
      fails++;
      $display("FAIL relfull_edge: got grant=%b count=%0d want 0000 7", bus.grant, bus.count);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0001 || bus.count !== 4'd8 || bus.full !== 1'b1) begin
      fails++;
      $display("FAIL relfull_regrant: got grant=%b count=%0d full=%b want 0001 8 1", bus.grant, bus.count, bus.full);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000) begin
      fails++;
      $display("FAIL relfull_hold: got grant=%b want 0000", bus.grant);
    end
    bus.req = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.req = 4'b0001;
    repeat (3) tick();
    bus.req = 4'b0100; bus.rel_valid = 1'b1;
    tick();
    bus.req = '0; bus.rel_valid = 1'b0;
    tests_run++;
    if (bus.grant !== 4'b0100 || bus.count !== 4'd3 || bus.err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL simul_grant_rel: got grant=%b count=%0d err=%b want 0100 3 0",
               bus.grant, bus.count, bus.err_underflow);
    end
  endtask

  task automatic test_drain();
    do_reset();
    bus.req = 4'b0011;
    repeat (2) tick();
    bus.req = 4'b1111; bus.drain = 1'b1;
    tick();
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.count !== 4'd2 || bus.drain_done !== 1'b0) begin
      fails++;
      $display("FAIL drain_block: got grant=%b count=%0d dd=%b want 0000 2 0", bus.grant, bus.count, bus.drain_done);
    end
    bus.rel_valid = 1'b1;
    tick();
    tick();
    bus.rel_valid = 1'b0;
    tests_run++;
    if (bus.count !== 4'd0 || bus.drain_done !== 1'b1 || bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL drain_done: got count=%0d dd=%b empty=%b want 0 1 1", bus.count, bus.drain_done, bus.empty);
    end
    tick();
    bus.drain = 1'b0;
    tick();
    tests_run++;
    if (bus.drain_done !== 1'b0 || bus.grant !== 4'b0000) begin
      fails++;
      $display("FAIL drain_exit: got dd=%b grant=%b want 0 0000", bus.drain_done, bus.grant);
    end
    tick();
    tests_run++;
    if (bus.grant !== 4'b0100 || bus.count !== 4'd1) begin
      fails++;
      $display("FAIL drain_resume: got grant=%b count=%0d want 0100 1", bus.grant, bus.count);
    end
    // Drain from an empty pool: done two cycles after drain rises.
    bus.req = '0; bus.rel_valid = 1'b1;
    tick();
    bus.rel_valid = 1'b0; bus.drain = 1'b1;
    tick();
    tests_run++;
    if (bus.drain_done !== 1'b0) begin
      fails++;
      $display("FAIL drain_empty_early: got dd=%b want 0", bus.drain_done);
    end
    tick();
    tests_run++;
    if (bus.drain_done !== 1'b1) begin
      fails++;
      $display("FAIL drain_empty_done: got dd=%b want 1", bus.drain_done);
    end
    bus.drain = 1'b0;
    tick();
  endtask

  task automatic test_underflow_and_reset();
    do_reset();
    bus.rel_valid = 1'b1;
    tick();
    bus.rel_valid = 1'b0;
    tests_run++;
    if (bus.count !== 4'd0 || bus.err_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow: got count=%0d err=%b want 0 1", bus.count, bus.err_underflow);
    end
    bus.req = 4'b0001;
    repeat (5) tick();
    tests_run++;
    if (bus.count !== 4'd5 || bus.err_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_sticky: got count=%0d err=%b want 5 1", bus.count, bus.err_underflow);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.count !== 4'd0 || bus.grant !== 4'b0000 || bus.empty !== 1'b1 || bus.err_underflow !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got count=%0d grant=%b empty=%b err=%b want 0 0000 1 0",
               bus.count, bus.grant, bus.empty, bus.err_underflow);
    end
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

`ifdef POOL_ARB_OWNER_CHECK_EN
  task automatic test_owner();
    do_reset();
    bus.req = 4'b0001;
    repeat (2) tick();
    bus.req = '0; bus.rel_valid = 1'b1; bus.rel_id = 2'd1;
    tick();
    tests_run++;
    if (bus.count !== 4'd2 || bus.err_underflow !== 1'b1) begin
      fails++;
      $display("FAIL owner_reject: got count=%0d err=%b want 2 1", bus.count, bus.err_underflow);
    end
    bus.rel_id = 2'd0;
    tick();
    bus.rel_valid = 1'b0;
    tests_run++;
    if (bus.count !== 4'd1) begin
      fails++;
      $display("FAIL owner_accept: got count=%0d want 1", bus.count);
    end
  endtask
`endif

  task automatic test_random();
    logic [8:0] obs, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.req       = 4'($urandom);
      bus.rel_valid = ($urandom_range(0, 2) == 0);
      bus.rel_id    = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus.drain = ~bus.drain;
      tick();
      obs = {bus.grant, bus.full, bus.empty, bus.drain_done, bus.err_underflow, 1'b0};
      exp = {m_grant, m_count == CAP, m_count == 0, m_mode == 2, m_err, 1'b0};
      $display("[TB] cyc %0d req=%b rel=%b id=%0d drain=%b -> grant=%b count=%0d",
               c, bus.req, bus.rel_valid, bus.rel_id, bus.drain, bus.grant, bus.count);
      tests_run++;
      if (obs !== exp || bus.count !== 4'(m_count)) begin
        fails++;
        $display("FAIL random_cyc%0d: got grant/full/empty/dd/err=%b count=%0d want %b count=%0d",
                 c, obs[8:1], bus.count, exp[8:1], m_count);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_fill();
    test_release_full();
    test_simultaneous();
    test_drain();
    test_underflow_and_reset();
`ifdef POOL_ARB_OWNER_CHECK_EN
    test_owner();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
